data_split: RTL

Byte-to-slice serializer; the transmit-side counterpart of data_consolidation. It accepts DIN_W-bit words on a valid/ready handshake and buffers them in a small input FIFO. Each word is emitted as DIN_W/DOUT_W consecutive DOUT_W-bit slices, MSB slice first, with dout_en qualifying each slice. Its output feeds data_consolidation directly, so the pair forms a loopback path.

---
 rtl/data_split_pkg.sv | 15 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/data_split.sv | 101 ++++++++++
 3 files changed

// File: rtl/data_split_pkg.sv
// Shared types and sizing helpers for the data_split word-to-slice serializer.
package data_split_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic int calc_ratio(input int din_w, input int dout_w);
    return din_w / dout_w;
  endfunction

  // A ratio of 1 still needs a 1-bit counter so the port widths stay legal.
  function automatic int calc_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a plain compare.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/data_split.sv
// Buffers DIN_W-bit words and emits each as RATIO DOUT_W-bit slices, MSB slice
// first, with back-to-back words running without a gap on dout_en.
module data_split
  import data_split_pkg::*;
#(
  parameter int DIN_W      = 8,
  parameter int DOUT_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_en,
  output logic              din_rdy,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_en,
  output logic              busy,
  output logic              ovf
);

  localparam int RATIO = calc_ratio(DIN_W, DOUT_W);
  localparam int CNT_W = calc_cnt_w(RATIO);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIN_W-1:0] shreg;
  logic [DIN_W-1:0] shifted;
  logic [DIN_W-1:0] head;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_push;
  logic [LVL_W-1:0] level_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             last_slice;
  logic             stay_shift;

  assign push       = din_en && din_rdy;
  assign last_slice = (state == SHIFT) && (cnt == CNT_W'(RATIO - 1));
  assign pop        = !fifo_empty && ((state == IDLE) || last_slice);
  assign stay_shift = pop || ((state == SHIFT) && !last_slice);
  assign shifted    = shreg << DOUT_W;

  // Occupancy ignores a same-edge pop so din_rdy can never admit a push into a full FIFO.
  assign level_push = level + LVL_W'(push);
  assign level_next = level_push - LVL_W'(pop);

  sync_fifo #(
    .WIDTH (DIN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push && !fifo_full),
    .wr_data (din),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      level   <= '0;
      din_rdy <= 1'b0;
      dout    <= '0;
      dout_en <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      din_rdy <= (level_push != LVL_W'(FIFO_DEPTH));
      level   <= level_next;
      busy    <= (|level_next) || stay_shift;
      if (din_en && !din_rdy)
        ovf <= 1'b1;

      if (pop) begin
        shreg   <= head;
        dout    <= head[DIN_W-1 -: DOUT_W];
        dout_en <= 1'b1;
        cnt     <= '0;
        state   <= SHIFT;
      end else if ((state == SHIFT) && !last_slice) begin
        shreg   <= shifted;
        dout    <= shifted[DIN_W-1 -: DOUT_W];
        cnt     <= cnt + CNT_W'(1);
      end else begin
        dout    <= '0;
        dout_en <= 1'b0;
        cnt     <= '0;
        state   <= IDLE;
      end
    end
  end

endmodule
